uart_boot_loader: RTL

Boot-time programming engine sitting upstream of the memory on the shared CPU/memory bus. While `programming` is high it receives a byte stream on `rxd` (8N1 UART), packs bytes little-endian into `DATA_WIDTH` words, and issues one bus write per word to consecutive addresses starting at 0. It drives `addr`, `wrt_data`, `req_valid` and `we` in place of the core, and consumes the memory's `data_valid` acknowledge. Status outputs report word count, completion and errors.

---
 rtl/uart_boot_loader_pkg.sv | 34 +++
 rtl/uart_rx_core.sv | 105 ++++++++++
 rtl/uart_boot_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_boot_loader_pkg
//   Shared system parameters for the boot loader slice: default bus widths,
//   bus handshake levels, the default UART bit period and the state encodings
//   of the receiver and bus FSMs.
// -----------------------------------------------------------------------------
package uart_boot_loader_pkg;

  // Bus geometry defaults (byte-addressed bus).
  localparam int DEFAULT_DATA_WIDTH   = 32;
  localparam int DEFAULT_ADDR_WIDTH   = 32;

  // 100 MHz clock / 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Bus handshake levels: a request is active high, writes are active high.
  localparam logic REQ_ACTIVE = 1'b1;
  localparam logic WE_WRITE   = 1'b1;

  // UART receiver states.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Bus write states.
  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_REQ  = 1'b1
  } bus_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   8N1 UART receiver with a 2-FF input synchronizer. The start bit is
//   re-checked half a bit after the falling edge to reject glitches; data bits
//   are then sampled one bit period apart, LSB first, followed by one stop
//   sample. Dropping `programming` aborts any byte in progress.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   programming  receiver enable; low forces IDLE
//   rxd          raw serial input, idle high
//   byte_valid   one-cycle pulse: byte_data holds an accepted byte
//   byte_data    received byte
//   frame_err    one-cycle pulse: stop bit sampled low, byte discarded
// -----------------------------------------------------------------------------
module uart_rx_core
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       programming,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             rxd_s;
  rx_state_t        state, state_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             tick;

  assign rxd_s     = sync_q[1];
  assign byte_data = shift_q;

  // The start check waits half a bit; every later sample waits a full bit.
  assign tick = (state == RX_START) ? (clk_cnt == HALF_CNT) : (clk_cnt == FULL_CNT);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      RX_IDLE:  if (!rxd_s) state_next = RX_START;
      RX_START: if (tick) state_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_cnt == 3'd7) state_next = RX_STOP;
      RX_STOP: begin
        if (tick) begin
          state_next = RX_IDLE;
          byte_valid = rxd_s;
          frame_err  = !rxd_s;
        end
      end
      default:  state_next = RX_IDLE;
    endcase
    if (!programming) begin
      state_next = RX_IDLE;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // The synchronizer resets to the idle line level so reset release
      // cannot look like a start bit.
      sync_q  <= 2'b11;
      state   <= RX_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // sees the pre-edge value of every other flop, independent of order.
      sync_q <= {sync_q[0], rxd};
      state  <= state_next;

      if (state == RX_IDLE || tick || state_next != state)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + CNT_W'(1);

      if (state == RX_START)
        bit_cnt <= '0;
      else if (state == RX_DATA && tick)
        bit_cnt <= bit_cnt + 3'd1;

      if (state == RX_DATA && tick)
        shift_q <= {rxd_s, shift_q[7:1]};
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// -----------------------------------------------------------------------------
// uart_boot_loader
//   Boot-time programming engine. While `programming` is high, bytes from the
//   UART are packed little-endian into DATA_WIDTH words and each word is
//   written to consecutive byte addresses starting at 0 through a one-entry
//   write buffer and a request/acknowledge bus FSM.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   programming  high: loader owns the bus and accepts bytes
//   rxd          UART serial input, idle high
//   addr         write byte address
//   wrt_data     write data
//   req_valid    bus request, held until data_valid
//   we           write enable, equal to req_valid
//   data_valid   memory acknowledge of the current request
//   word_count   words written since programming rose
//   boot_done    one-cycle pulse once programming is low and writes drained
//   frame_err    sticky: a stop bit was sampled low
//   overrun      sticky: a completed word was dropped (buffer busy)
// -----------------------------------------------------------------------------
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  programming,
  input  logic                  rxd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wrt_data,
  output logic                  req_valid,
  output logic                  we,
  input  logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  boot_done,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int                    LANES     = DATA_WIDTH / 8;
  localparam int                    LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(LANES);

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  frame_pulse;
  logic                  prog_d;
  logic                  prog_rise, prog_fall;
  logic [LANE_W-1:0]     lane;
  logic [DATA_WIDTH-1:0] pack_data;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  word_done;
  logic                  ack;
  logic                  buf_free;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  done_pending;
  bus_state_t            bus_state, bus_next;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .programming (programming),
    .rxd         (rxd),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_err   (frame_pulse)
  );

  assign prog_rise = programming && !prog_d;
  assign prog_fall = !programming && prog_d;

  // Packed word including the byte arriving this cycle.
  always_comb begin
    word_next = pack_data;
    word_next[int'(lane) * 8 +: 8] = byte_data;
  end

  assign word_done = byte_valid && (lane == LAST_LANE);
  assign ack       = (bus_state == BUS_REQ) && data_valid;
  // An ack on the same edge frees the buffer for the word completing now.
  assign buf_free  = !buf_full || ack;

  assign req_valid = (bus_state == BUS_REQ) ? REQ_ACTIVE : !REQ_ACTIVE;
  assign we        = req_valid ? WE_WRITE : !WE_WRITE;
  assign wrt_data  = buf_data;

  always_comb begin
    bus_next = bus_state;
    unique case (bus_state)
      BUS_IDLE: if (buf_full) bus_next = BUS_REQ;
      BUS_REQ:  if (data_valid) bus_next = BUS_IDLE;
      default:  bus_next = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus_state <= BUS_IDLE;
    else        bus_state <= bus_next;
  end

  // Byte packer. Partial words are dropped whenever programming is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prog_d    <= 1'b0;
      lane      <= '0;
      pack_data <= '0;
    end else begin
      prog_d <= programming;
      if (!programming || prog_rise) begin
        lane      <= '0;
        pack_data <= '0;
      end else if (byte_valid) begin
        pack_data <= word_next;
        lane      <= word_done ? '0 : lane + LANE_W'(1);
      end
    end
  end

  // Write buffer, address/count and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full     <= 1'b0;
      buf_data     <= '0;
      addr         <= '0;
      word_count   <= '0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      boot_done    <= 1'b0;
      done_pending <= 1'b0;
    end else begin
      boot_done <= 1'b0;

      if (ack) begin
        buf_full   <= 1'b0;
        addr       <= addr + ADDR_STEP;
        word_count <= word_count + ADDR_WIDTH'(1);
      end

      if (word_done) begin
        if (buf_free) begin
          buf_data <= word_next;
          buf_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (frame_pulse) frame_err <= 1'b1;

      if (prog_fall) begin
        done_pending <= 1'b1;
      end else if (done_pending && bus_state == BUS_IDLE && !buf_full) begin
        boot_done    <= 1'b1;
        done_pending <= 1'b0;
      end

      if (prog_rise) begin
        addr         <= '0;
        word_count   <= '0;
        frame_err    <= 1'b0;
        overrun      <= 1'b0;
        done_pending <= 1'b0;
      end
    end
  end

endmodule
